// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg
// Shared definitions for the ROM boot loader: FSM state encodings, the
// default frame start marker and the SoC register-bus width used as the
// default ROM port width.
package rom_loader_pkg;

  localparam int         REG_BUS_W      = 32;
  localparam logic [7:0] START_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

endpackage

// File: rtl/rom_loader.sv
// rom_loader
// Boots a program image into the instruction ROM from a UART byte stream
// while the core is held in reset.
// Frame: START_BYTE, N[7:0], N[15:8], N words of 4 little-endian bytes,
// then one XOR checksum byte over the payload bytes.
//
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   rx_valid, rx_data    incoming byte from UART RX
//   rx_ready             byte accepted this cycle when rx_valid & rx_ready
//   wen, w_addr, w_data  ROM write port (w_addr is a word index)
//   cpu_hold             holds the core while a frame is in progress
//   load_busy            loader is not idle
//   load_done            one-cycle pulse on a frame with a good checksum
//   load_err             sticky error, cleared by the next accepted start byte
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         DW         = REG_BUS_W,
  parameter int         AW         = REG_BUS_W,
  parameter int         MEM_NUM    = 4096,
  parameter logic [7:0] START_BYTE = START_BYTE_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wen,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          cpu_hold,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err
);

  state_t      state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  csum;
  logic [23:0] word;
  logic [1:0]  byte_cnt;

  logic        xfer;
  logic [15:0] len_next;
  logic [15:0] idx_inc;

  assign xfer     = rx_valid & rx_ready;
  assign len_next = {rx_data, len[7:0]};
  assign idx_inc  = idx + 16'd1;

  // These outputs are pure decodes of the state register, so they change
  // only on the clock edge. WRITE is the single cycle where the byte stream
  // is stalled and the ROM write is issued.
  assign rx_ready  = (state != S_WRITE);
  assign wen       = (state == S_WRITE);
  assign load_busy = (state != S_IDLE);

  // Frame parser. The lower three bytes of a word are shifted in from the
  // top so that, when the fourth byte arrives, {rx_data, word} is already
  // the little-endian assembled word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_IDLE;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      w_addr    <= '0;
      w_data    <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && rx_data == START_BYTE) begin
            state    <= S_LEN_LO;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            csum     <= '0;
            idx      <= '0;
            byte_cnt <= '0;
            w_addr   <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= rx_data;
            if ({16'd0, len_next} > 32'(MEM_NUM)) begin
              load_err <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= S_IDLE;
            end else if (len_next == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            word     <= {rx_data, word[23:8]};
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              w_data <= DW'({rx_data, word});
              w_addr <= AW'(idx);
              state  <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          idx <= idx_inc;
          if (idx_inc == len) state <= S_CSUM;
          else                state <= S_DATA;
        end
        S_CSUM: begin
          if (xfer) begin
            if (rx_data == csum) load_done <= 1'b1;
            else                 load_err  <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader
// Self-checking bench for rom_loader. Frames are built from a list of words
// (directed or $urandom); the expected ROM writes, checksum and outcome are
// derived from that list, and the DUT's writes are captured by a monitor.
module tb_rom_loader;

  logic        clk;
  logic        rstn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_err;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state: words of the frame, bytes on the wire
  logic [31:0] ew[$];
  logic [7:0]  fb[$];

  // observed writes and done pulses
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          done_cnt = 0;

  rom_loader #(
    .DW(32), .AW(32), .MEM_NUM(4096), .START_BYTE(8'hA5)
  ) dut (
    .clk(clk), .rstn(rstn),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .wen(wen), .w_addr(w_addr), .w_data(w_data),
    .cpu_hold(cpu_hold), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Monitor: record ROM writes and done pulses; the stream may only stall
  // during the write cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (wen) begin
        wa.push_back(w_addr);
        wd.push_back(w_data);
      end
      if (load_done) done_cnt++;
    end
    checkOutput("rx_ready_vs_wen", 32'(rx_ready), 32'(!wen));
  end

  // Build the wire bytes for the words in ew; optionally corrupt checksum.
  function automatic void makeFrame(input bit bad);
    int n;
    logic [7:0] cs;
    n  = ew.size();
    fb = {};
    fb.push_back(8'hA5);
    fb.push_back(8'(n));
    fb.push_back(8'(n >> 8));
    cs = 8'h00;
    foreach (ew[i]) begin
      for (int b = 0; b < 4; b++) begin
        logic [7:0] v;
        v = 8'(ew[i] >> (8 * b));
        fb.push_back(v);
        cs = cs ^ v;
      end
    end
    fb.push_back(bad ? (cs ^ 8'h01) : cs);
  endfunction

  function automatic void randomWords(input int n);
    ew = {};
    repeat (n) ew.push_back($urandom);
  endfunction

  function automatic void clearObs();
    wa = {};
    wd = {};
    done_cnt = 0;
  endfunction

  // Send fb byte by byte; called and returns just after a falling edge.
  task automatic applyStimulus(input bit gaps);
    int n;
    n = ew.size();
    for (int j = 0; j < fb.size(); j++) begin
      int tries;
      int k;
      tries = 0;
      rx_valid = 1'b1;
      rx_data  = fb[j];
      while (!rx_ready && tries < 16) begin
        @(negedge clk);
        tries++;
      end
      if (!rx_ready) begin
        checkOutput("rx_ready_timeout", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      if (j == 0 && fb[0] == 8'hA5) begin
        checkOutput("hold_after_start", 32'(cpu_hold), 32'd1);
        checkOutput("busy_after_start", 32'(load_busy), 32'd1);
      end
      if (j >= 3 && j < 3 + 4 * n && ((j - 3) % 4) == 3) begin
        k = (j - 3) / 4;
        checkOutput("wen_latency", 32'(wen), 32'd1);
        checkOutput("w_addr", w_addr, 32'(k));
        checkOutput("w_data", w_data, ew[k]);
      end
      if (gaps) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic checkFrameResult(input int exp_done, input bit exp_err,
                                  input int exp_n);
    @(negedge clk);
    checkOutput("done_count", 32'(done_cnt), 32'(exp_done));
    checkOutput("done_pulse_width", 32'(load_done), 32'd0);
    checkOutput("load_err", 32'(load_err), 32'(exp_err));
    checkOutput("cpu_hold_end", 32'(cpu_hold), 32'd0);
    checkOutput("busy_end", 32'(load_busy), 32'd0);
    checkOutput("write_count", 32'(wa.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wa.size(); i++) begin
      checkOutput("rom_addr", wa[i], 32'(i));
      checkOutput("rom_data", wd[i], ew[i]);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst_wen", 32'(wen), 32'd0);
    checkOutput("rst_w_addr", w_addr, 32'd0);
    checkOutput("rst_w_data", w_data, 32'd0);
    checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    checkOutput("rst_busy", 32'(load_busy), 32'd0);
    checkOutput("rst_done", 32'(load_done), 32'd0);
    checkOutput("rst_err", 32'(load_err), 32'd0);
  endtask

  task automatic resetDut();
    rx_valid = 1'b0;
    rstn = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit bad;
    int n;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rstn     = 1'b0;
    #1;
    checkResetValues();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] normal two-word frame");
    ew = {32'h12345678, 32'hDEADBEEF};
    makeFrame(1'b0);
    clearObs();
    applyStimulus(1'b1);
    checkFrameResult(1, 1'b0, 2);

    $display("[TB] bad checksum");
    makeFrame(1'b1);
    clearObs();
    applyStimulus(1'b0);
    checkFrameResult(0, 1'b1, 2);

    $display("[TB] valid frame clears error");
    randomWords(3);
    makeFrame(1'b0);
    clearObs();
    applyStimulus(1'b1);
    checkFrameResult(1, 1'b0, 3);

    $display("[TB] oversize length");
    ew = {};
    fb = {8'hA5, 8'h01, 8'h10};
    clearObs();
    applyStimulus(1'b0);
    checkOutput("oversize_err_now", 32'(load_err), 32'd1);
    checkOutput("oversize_hold_now", 32'(cpu_hold), 32'd0);
    checkFrameResult(0, 1'b1, 0);

    $display("[TB] zero length");
    ew = {};
    makeFrame(1'b0);
    clearObs();
    applyStimulus(1'b1);
    checkFrameResult(1, 1'b0, 0);

    $display("[TB] idle garbage, start byte inside payload");
    ew = {};
    fb = {};
    repeat (5) fb.push_back(8'($urandom_range(0, 8'hA4)));
    clearObs();
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("garbage_busy", 32'(load_busy), 32'd0);
    checkOutput("garbage_hold", 32'(cpu_hold), 32'd0);
    ew = {32'hA5A5A5A5, $urandom};
    makeFrame(1'b0);
    clearObs();
    applyStimulus(1'b1);
    checkFrameResult(1, 1'b0, 2);

    $display("[TB] back-to-back random frames");
    for (int t = 0; t < 4; t++) begin
      n   = $urandom_range(1, 6);
      bad = (t == 2);
      randomWords(n);
      makeFrame(bad);
      clearObs();
      applyStimulus(1'b0);
      checkFrameResult(bad ? 0 : 1, bad, n);
    end

    $display("[TB] length equal to depth is accepted");
    ew = {};
    fb = {8'hA5, 8'h00, 8'h10};
    clearObs();
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("maxlen_busy", 32'(load_busy), 32'd1);
    checkOutput("maxlen_err", 32'(load_err), 32'd0);
    checkOutput("maxlen_hold", 32'(cpu_hold), 32'd1);
    resetDut();

    $display("[TB] reset mid-frame");
    randomWords(2);
    makeFrame(1'b0);
    fb = fb[0:8];
    clearObs();
    applyStimulus(1'b1);
    rstn = 1'b0;
    #1;
    checkResetValues();
    checkOutput("midrst_writes", 32'(wa.size()), 32'd1);
    if (wa.size() > 0) checkOutput("midrst_data0", wd[0], ew[0]);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] full frame after reset");
    randomWords(3);
    makeFrame(1'b0);
    clearObs();
    applyStimulus(1'b1);
    checkFrameResult(1, 1'b0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Upstream feeder of the instruction ROM's write port; boots a program image into ROM from a byte stream (UART RX) while the core is held.
- Frame format: start byte, 16-bit little-endian word count N, N words of 4 bytes each (little-endian), then 1 XOR checksum byte over all payload bytes.
- Emits one ROM write per assembled word and reports done/error to the SoC reset logic.

Parameters:
- DW, 32, data width of ROM write port
- AW, 32, address width of ROM write port
- MEM_NUM, 4096, ROM depth in words; upper bound on N
- START_BYTE, 8'hA5, frame start marker

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- rx_valid  input  1  byte available from UART RX
- rx_data  input  8  received byte
- rx_ready  output  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
- wen  output  1  ROM write enable, single-cycle pulse
- w_addr  output  AW  ROM word index (not byte address), 0..N-1
- w_data  output  DW  assembled word
- cpu_hold  output  1  keeps core in reset while a frame is in progress
- load_busy  output  1  FSM not in IDLE
- load_done  output  1  one-cycle pulse on successful frame end
- load_err  output  1  sticky error flag; cleared when the next START_BYTE is accepted

Behaviour:
- Reset (async, rstn=0): state=IDLE; all outputs 0 except rx_ready=1; internal counters, checksum and word register cleared.
- States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM.
- IDLE: rx_ready=1. Bytes other than START_BYTE are discarded. Accepting START_BYTE moves to LEN_LO, sets cpu_hold=1, clears load_err, clears the checksum and w_addr.
- LEN_LO / LEN_HI: capture N[7:0] then N[15:8]. On leaving LEN_HI:
  - N > MEM_NUM: load_err=1, cpu_hold=0, go to IDLE.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: accepts bytes into lane byte_cnt (0..3, little-endian) and XORs each into the checksum. Accepting the 4th byte moves to WRITE.
- WRITE: exactly one cycle. wen=1, w_data=assembled word, w_addr=current index; rx_ready=0.
  - Next cycle: index+1.
  - If index+1 == N, go to CSUM; else return to DATA.
- Latency: wen is asserted the cycle immediately after the 4th byte of a word is accepted.
- w_addr and w_data hold their values outside WRITE; consumers must qualify them with wen only.
- CSUM: accepts 1 byte.
  - Byte equals the checksum: load_done pulses for 1 cycle.
  - Otherwise: load_err=1.
  - Either way: cpu_hold=0, go to IDLE.
- rx_ready=1 in every state except WRITE. A byte presented during WRITE is held by the upstream and taken next cycle.
- load_busy = (state != IDLE).
- Index and N arithmetic is 16-bit; w_addr is the index zero-extended to AW. Checksum is 8-bit XOR of payload bytes only (start and length bytes excluded).
- No timeout. A stalled frame keeps cpu_hold asserted until rstn is asserted.
- Reset mid-frame: all state is discarded immediately; words already written stay in ROM; cpu_hold drops.
- START_BYTE appearing inside the payload is treated as data, not as a restart.

Decomposition:
- Shared defines header:
  - FSM state encodings (3-bit localparams)
  - START_BYTE default
  - RegBus width already present
- No sub-module required. If the core wires rx_valid/rx_data to the UART receiver through a skid buffer, that buffer lives outside this block.

Test Plan:
- Normal load: A5, 02, 00, 78 56 34 12, EF BE AD DE, csum = 0x12^0x34^0x56^0x78^0xDE^0xAD^0xBE^0xEF.
  - Expect wen at idx0 with data 0x12345678, then idx1 with data 0xDEADBEEF.
  - Expect one load_done pulse, cpu_hold 1→0, load_err=0.
- Bad checksum: same frame with csum^0x01.
  - Expect both writes, load_err=1, no load_done, state IDLE.
  - A following valid frame clears load_err.
- Oversize: A5, 01, 10 (N=4097, MEM_NUM=4096).
  - Expect load_err=1 right after the 3rd byte, no wen, cpu_hold=0.
- Zero length: A5, 00, 00, 00.
  - Expect load_done, no wen.
- Back-to-back bytes with rx_valid held high across WRITE.
  - Expect rx_ready=0 exactly during each WRITE cycle, no byte lost, and assembled words correct.
- Reset mid-frame: assert rstn=0 after the 2nd word's 2nd byte.
  - Expect all outputs at reset values and only idx0 written.
  - A new full frame after reset loads correctly.
